// File: rtl/pattern_stream_generator_if.sv
// Handshake bundle for pattern_stream_generator: frame request inputs and serial outputs.
interface pattern_stream_generator_if #(
  parameter int unsigned PAT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] string1;
  logic [3:0]       n_req;
  logic             string2;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [2:0]       sent;

  modport master (
    output start, string1, n_req,
    input  string2, bit_valid, busy, done, sent
  );

  modport slave (
    input  start, string1, n_req,
    output string2, bit_valid, busy, done, sent
  );
endinterface

// File: rtl/pattern_stream_generator.sv
// Serial frame generator: packs up to FRAME_BITS/PAT_W copies of a pattern LSB first, pads
// with the complement of pattern bit 0, then emits a one-cycle done gap.
module pattern_stream_generator #(
  parameter int unsigned FRAME_BITS = 20,
  parameter int unsigned PAT_W      = 4
) (
  input logic                       clk,
  input logic                       rst,
  pattern_stream_generator_if.slave bus
);
  localparam int unsigned MaxCopies = FRAME_BITS / PAT_W;
  localparam int unsigned IdxW      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned PosW      = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e           r_state, w_state_d;
  logic [IdxW-1:0]  r_idx, w_idx_d;
  logic [PAT_W-1:0] r_pat, w_pat_d;
  logic [3:0]       r_copies, w_copies_d;
  logic             r_fill, w_fill_d;
  logic             r_string2, w_string2_d;
  logic             r_bit_valid, w_bit_valid_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic [2:0]       r_sent, w_sent_d;
  logic [3:0]       w_clamp;

  function automatic logic f_bit(input logic [IdxW-1:0]  idx,
                                 input logic [PAT_W-1:0] pat,
                                 input logic [3:0]       copies,
                                 input logic             fill);
    int unsigned pos;
    if (32'(idx) < 32'(copies) * PAT_W) begin
      pos = 32'(idx) % PAT_W;
      return pat[PosW'(pos)];
    end
    return fill;
  endfunction

  assign w_clamp = (32'(bus.n_req) < MaxCopies) ? bus.n_req : 4'(MaxCopies);

  // Outputs are registered from the next-state decode, so r_idx is the index of the bit
  // being loaded; the done cycle is already IDLE and can accept a back-to-back start.
  always_comb begin
    w_state_d     = r_state;
    w_idx_d       = r_idx;
    w_pat_d       = r_pat;
    w_copies_d    = r_copies;
    w_fill_d      = r_fill;
    w_sent_d      = r_sent;
    w_string2_d   = 1'b0;
    w_bit_valid_d = 1'b0;
    w_busy_d      = 1'b0;
    w_done_d      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_pat_d       = bus.string1;
          w_copies_d    = w_clamp;
          w_fill_d      = ~bus.string1[0];
          w_sent_d      = 3'(w_clamp);
          w_string2_d   = f_bit('0, bus.string1, w_clamp, ~bus.string1[0]);
          w_bit_valid_d = 1'b1;
          w_busy_d      = 1'b1;
          w_idx_d       = IdxW'(1);
          w_state_d     = (FRAME_BITS > 1) ? StSend : StGap;
        end
      end
      StSend: begin
        w_string2_d   = f_bit(r_idx, r_pat, r_copies, r_fill);
        w_bit_valid_d = 1'b1;
        w_busy_d      = 1'b1;
        if (r_idx == LastIdx) begin
          w_state_d = StGap;
        end else begin
          w_idx_d = r_idx + 1'b1;
        end
      end
      StGap: begin
        w_done_d  = 1'b1;
        w_busy_d  = 1'b1;
        w_idx_d   = '0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_pat       <= '0;
      r_copies    <= '0;
      r_fill      <= 1'b0;
      r_string2   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sent      <= '0;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_pat       <= w_pat_d;
      r_copies    <= w_copies_d;
      r_fill      <= w_fill_d;
      r_string2   <= w_string2_d;
      r_bit_valid <= w_bit_valid_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_sent      <= w_sent_d;
    end
  end

  assign bus.string2   = r_string2;
  assign bus.bit_valid = r_bit_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sent      = r_sent;
endmodule
